// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: Pong ball position/velocity registers, advanced once per frame with wall bounces, paddle hits, serves and misses
// Ports: clk/reset (sync, active-high); frame_tick pulse per frame; srv_l/srv_r serve levels;
//   visible (low freezes everything); paddle_l_y/paddle_r_y paddle tops;
//   ball_x/ball_y ball top-left; ball_active draw enable; miss_l/miss_r held miss flags; hit contact pulse.
module ball_motion_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int SPEED_X     = 4,
  parameter int SPEED_Y     = 2,
  parameter int MAX_SPEED_X = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       srv_l,
  input  logic       srv_r,
  input  logic       visible,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       miss_l,
  output logic       miss_r,
  output logic       hit
);
  typedef enum logic [1:0] {IDLE, MOVE, MISS} st_t;
  localparam logic signed [10:0] L_FACE = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [10:0] R_FACE = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [10:0] X_MAX  = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] SY     = 11'(SPEED_Y);
  localparam logic [9:0] X_RST   = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_RST   = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] SRV_OFS = 10'((PADDLE_H - BALL_SIZE) / 2);
  localparam logic [3:0] SPD0    = 4'(SPEED_X);
  localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED_X);
  st_t        st_q, st_d;
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic       vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [3:0] speed_q, speed_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  logic       miss_l_q, miss_l_d, miss_r_q, miss_r_d, hit_q, hit_d;
  logic signed [10:0] bxs, bys, nx, ny;
  logic       ovl_l, ovl_r, hit_l, hit_r;
  always_comb begin
    bxs   = $signed({1'b0, bx_q});
    bys   = $signed({1'b0, by_q});
    nx    = vx_neg_q ? bxs - $signed({7'd0, speed_q}) : bxs + $signed({7'd0, speed_q});
    ny    = vy_neg_q ? bys - SY : bys + SY;
    // overlap is judged on the pre-move y, strict on both sides
    ovl_l = ({1'b0, by_q} + 11'(BALL_SIZE) > {1'b0, paddle_l_y}) && ({1'b0, by_q} < {1'b0, paddle_l_y} + 11'(PADDLE_H));
    ovl_r = ({1'b0, by_q} + 11'(BALL_SIZE) > {1'b0, paddle_r_y}) && ({1'b0, by_q} < {1'b0, paddle_r_y} + 11'(PADDLE_H));
    // requiring the ball to start on the court side of the face stops hits from behind
    hit_l = vx_neg_q && bxs >= L_FACE && nx <= L_FACE && ovl_l;
    hit_r = !vx_neg_q && bxs <= R_FACE && nx >= R_FACE && ovl_r;
    st_d      = st_q;
    bx_d      = bx_q;
    by_d      = by_q;
    vx_neg_d  = vx_neg_q;
    vy_neg_d  = vy_neg_q;
    speed_d   = speed_q;
    hit_cnt_d = hit_cnt_q;
    miss_l_d  = miss_l_q;
    miss_r_d  = miss_r_q;
    hit_d     = 1'b0;
    if (visible && st_q != MOVE && (srv_l || srv_r)) begin
      st_d      = MOVE;
      bx_d      = srv_l ? L_FACE[9:0] : R_FACE[9:0];
      by_d      = (srv_l ? paddle_l_y : paddle_r_y) + SRV_OFS;
      vx_neg_d  = !srv_l;
      vy_neg_d  = !srv_l;
      speed_d   = SPD0;
      hit_cnt_d = 2'd0;
      miss_l_d  = 1'b0;
      miss_r_d  = 1'b0;
    end else if (visible && st_q == MOVE && frame_tick) begin
      by_d     = ny <= 11'sd0 ? 10'd0 : ny >= Y_MAX ? Y_MAX[9:0] : ny[9:0];
      vy_neg_d = ny <= 11'sd0 ? 1'b0 : ny >= Y_MAX ? 1'b1 : vy_neg_q;
      bx_d     = hit_l ? L_FACE[9:0] : hit_r ? R_FACE[9:0] : nx <= 11'sd0 ? 10'd0 : nx >= X_MAX ? X_MAX[9:0] : nx[9:0];
      vx_neg_d = hit_l ? 1'b0 : hit_r ? 1'b1 : vx_neg_q;
      hit_d    = hit_l || hit_r;
      miss_l_d = !hit_d && nx <= 11'sd0;
      miss_r_d = !hit_d && !miss_l_d && nx >= X_MAX;
      st_d     = (miss_l_d || miss_r_d) ? MISS : MOVE;
      hit_cnt_d = hit_d ? hit_cnt_q + 2'd1 : hit_cnt_q;
      speed_d   = (hit_d && hit_cnt_q == 2'd3) ? (speed_q < SPD_MAX ? speed_q + 4'd1 : SPD_MAX) : speed_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      bx_q      <= X_RST;
      by_q      <= Y_RST;
      vx_neg_q  <= 1'b0;
      vy_neg_q  <= 1'b0;
      speed_q   <= SPD0;
      hit_cnt_q <= 2'd0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      vx_neg_q  <= vx_neg_d;
      vy_neg_q  <= vy_neg_d;
      speed_q   <= speed_d;
      hit_cnt_q <= hit_cnt_d;
      miss_l_q  <= miss_l_d;
      miss_r_q  <= miss_r_d;
      hit_q     <= hit_d;
    end
  end
  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign ball_active = st_q == MOVE && visible;
  assign miss_l      = miss_l_q;
  assign miss_r      = miss_r_q;
  assign hit         = hit_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: scoreboard bench comparing the ball controller against an integer game model
module tb_ball_motion_ctrl;
  logic clk = 0, reset = 1, frame_tick = 0, srv_l = 0, srv_r = 0, visible = 1;
  logic [9:0] paddle_l_y = 0, paddle_r_y = 0;
  logic [9:0] ball_x, ball_y;
  logic ball_active, miss_l, miss_r, hit;
  ball_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .srv_l(srv_l), .srv_r(srv_r),
    .visible(visible), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_active(ball_active),
    .miss_l(miss_l), .miss_r(miss_r), .hit(hit)
  );
  always #5 clk = ~clk;
  typedef struct {int x; int y; bit a; bit ml; bit mr; bit h;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  // model: mode 0 waiting for serve, 1 in play, 2 missed
  int m_mode, m_x, m_y, m_dx, m_dy, m_spd, m_hits;
  bit m_ml, m_mr, m_hit;
  task automatic chk(string n, logic [9:0] act, logic [9:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ball_x", ball_x, 10'(e.x));
      chk("ball_y", ball_y, 10'(e.y));
      chk("ball_active", {9'd0, ball_active}, {9'd0, e.a});
      chk("miss_l", {9'd0, miss_l}, {9'd0, e.ml});
      chk("miss_r", {9'd0, miss_r}, {9'd0, e.mr});
      chk("hit", {9'd0, hit}, {9'd0, e.h});
    end
  end
  function automatic bit ovl(int y, int p);
    return (y + 8 > p) && (y < p + 64);
  endfunction
  task automatic model(bit rs, bit tk, bit sl, bit sr, bit vis, int pl, int pr);
    int nx, ny;
    bit hl, hr;
    m_hit = 0;
    if (rs) begin
      m_mode = 0; m_x = 316; m_y = 236; m_dx = 1; m_dy = 1; m_spd = 4; m_hits = 0; m_ml = 0; m_mr = 0;
    end else if (!vis) begin
    end else if (m_mode != 1 && (sl || sr)) begin
      m_mode = 1; m_spd = 4; m_hits = 0; m_ml = 0; m_mr = 0;
      m_x  = sl ? 24 : 608;
      m_y  = (sl ? pl : pr) + 28;
      m_dx = sl ? 1 : -1;
      m_dy = sl ? 1 : -1;
    end else if (m_mode == 1 && tk) begin
      nx = m_x + m_dx * m_spd;
      ny = m_y + m_dy * 2;
      hl = m_dx < 0 && m_x >= 24 && nx <= 24 && ovl(m_y, pl);
      hr = m_dx > 0 && m_x <= 608 && nx >= 608 && ovl(m_y, pr);
      if (ny <= 0) begin m_y = 0; m_dy = 1; end
      else if (ny >= 472) begin m_y = 472; m_dy = -1; end
      else m_y = ny;
      if (hl) begin m_x = 24; m_dx = 1; m_hit = 1; end
      else if (hr) begin m_x = 608; m_dx = -1; m_hit = 1; end
      else if (nx <= 0) begin m_x = 0; m_ml = 1; m_mode = 2; end
      else if (nx >= 632) begin m_x = 632; m_mr = 1; m_mode = 2; end
      else m_x = nx;
      if (m_hit) begin
        m_hits = (m_hits + 1) % 4;
        if (m_hits == 0) m_spd = (m_spd + 1 > 8) ? 8 : m_spd + 1;
      end
    end
  endtask
  task automatic step(bit rs, bit tk, bit sl, bit sr, bit vis, int pl, int pr);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rs; frame_tick = tk; srv_l = sl; srv_r = sr; visible = vis;
    paddle_l_y = 10'(pl); paddle_r_y = 10'(pr);
    model(rs, tk, sl, sr, vis, pl, pr);
    e.x = m_x; e.y = m_y; e.a = (m_mode == 1) && vis; e.ml = m_ml; e.mr = m_mr; e.h = m_hit;
    q.push_back(e);
  endtask
  function automatic int track(int y);
    int p;
    p = y - int'($urandom_range(0, 70));
    return p < 0 ? 0 : p > 416 ? 416 : p;
  endfunction
  initial begin
    int guard;
    bit vis;
    int pl, pr;
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 200, 0);
    step(0, 1, 0, 0, 1, 200, 0);
    guard = 0;
    while (m_mode == 1 && guard < 400) begin
      step(0, 1, 0, 0, 1, 200, 0);
      guard++;
    end
    total++;
    if (m_mode != 2 || !m_mr) begin
      bad++;
      $display("FAIL miss_r_reach actual=%0d required=2", m_mode);
    end
    repeat (100) step(0, 0, 0, 0, 1, 200, 0);
    step(0, 0, 0, 1, 1, 200, 100);
    step(0, 1, 0, 1, 1, 200, 100);
    vis = 1; pl = 200; pr = 100;
    for (int i = 0; i < 30000; i++) begin
      bit rs, tk, sl, sr;
      rs = $urandom_range(0, 2999) == 0;
      if (vis) vis = $urandom_range(0, 199) != 0;
      else vis = $urandom_range(0, 9) == 0;
      tk = $urandom_range(0, 3) != 0;
      sl = $urandom_range(0, 99) < (m_mode == 1 ? 1 : 4);
      sr = $urandom_range(0, 99) < (m_mode == 1 ? 1 : 4);
      if ($urandom_range(0, 9) != 0) pl = track(m_y);
      else if ($urandom_range(0, 9) == 0) pl = $urandom_range(0, 416);
      if ($urandom_range(0, 9) != 0) pr = track(m_y);
      else if ($urandom_range(0, 9) == 0) pr = $urandom_range(0, 416);
      step(rs, tk, sl, sr, vis, pl, pr);
    end
    step(0, 0, 0, 0, 1, pl, pr);
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
